// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider, signed or unsigned, one quotient bit per cycle.
// Operands are latched on accept; results are held until the next accepted operation.
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] prem;
  logic [WIDTH-1:0] orig_dvd;
  logic [CNT_W-1:0] count;
  logic             neg_q, neg_r;
  logic [WIDTH-1:0] abs_dvd, abs_dvs;
  logic [WIDTH+1:0] trial;
  logic             accept;

  assign accept  = (state == IDLE) && start;
  assign abs_dvd = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
  assign abs_dvs = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
  // Two guard bits: the top bit of the difference is the borrow, i.e. "trial < 0".
  assign trial   = {1'b0, prem, shreg[WIDTH-1]} - {2'b00, dvsr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (divisor == '0) ? FIX : ITER;
      end
      ITER:    if (count == CNT_W'(1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvsr        <= '0;
      shreg       <= '0;
      prem        <= '0;
      orig_dvd    <= '0;
      count       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        dvsr        <= abs_dvs;
        shreg       <= abs_dvd;
        prem        <= '0;
        orig_dvd    <= dividend;
        count       <= CNT_W'(WIDTH);
        neg_q       <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        neg_r       <= signed_op & dividend[WIDTH-1];
        div_by_zero <= 1'b0;
      end
      if (state == ITER) begin
        count <= count - CNT_W'(1);
        if (trial[WIDTH+1]) begin
          prem  <= {prem[WIDTH-2:0], shreg[WIDTH-1]};
          shreg <= {shreg[WIDTH-2:0], 1'b0};
        end else begin
          prem  <= trial[WIDTH-1:0];
          shreg <= {shreg[WIDTH-2:0], 1'b1};
        end
      end
      // A zero divisor is still zero after taking its absolute value.
      if (state == FIX) begin
        if (dvsr == '0) begin
          quotient    <= '1;
          remainder   <= orig_dvd;
          div_by_zero <= 1'b1;
        end else begin
          quotient    <= neg_q ? -shreg : shreg;
          remainder   <= neg_r ? -prem  : prem;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Randomized and directed self-checking bench for seq_divider at WIDTH=32.
// Expected results come from plain integer division in 64-bit arithmetic.
module tb_seq_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checkCount = 0;
  int failCount  = 0;

  seq_divider #(.WIDTH(32), .CNT_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation still running at 1ms, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Truncating division; remainder follows the dividend sign; x/0 gives all ones and x.
  task automatic refModel(input bit sop, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint sa, sb, sq, sr;
    dz = (b == 32'd0);
    if (dz) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sop) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sq = sa / sb;
      sr = sa % sb;
      q  = sq[31:0];
      r  = sr[31:0];
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  task automatic applyStimulus(input bit sop, input logic [31:0] a, input logic [31:0] b,
                               input int glitchAt);
    logic [31:0] eq, er;
    logic        edz;
    int          cyc;
    bit          seen;
    refModel(sop, a, b, eq, er, edz);
    @(negedge clk);
    start     = 1'b1;
    signed_op = sop;
    dividend  = a;
    divisor   = b;
    @(posedge clk);
    #1;
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    signed_op = 1'($urandom_range(0, 1));
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (glitchAt != 0 && cyc == glitchAt + 1) begin
        start = 1'b0;
        checkOutput("busy_after_glitch", {31'd0, busy}, 32'd1);
      end
      if (glitchAt != 0 && cyc == glitchAt) begin
        start    = 1'b1;
        dividend = $urandom;
        divisor  = 32'd3;
      end
      if (done) seen = 1'b1;
    end
    checkOutput("done_seen", {31'd0, seen}, 32'd1);
    checkOutput("latency", cyc, (b == 32'd0) ? 32'd2 : 32'd34);
    checkOutput("quotient", quotient, eq);
    checkOutput("remainder", remainder, er);
    checkOutput("div_by_zero", {31'd0, div_by_zero}, {31'd0, edz});
    checkOutput("busy_in_done", {31'd0, busy}, 32'd1);
    @(negedge clk);
    checkOutput("done_pulse_end", {31'd0, done}, 32'd0);
    checkOutput("busy_idle", {31'd0, busy}, 32'd0);
    checkOutput("quotient_held", quotient, eq);
  endtask

  // Waits for done, bounded, and compares results against the model.
  task automatic waitAndCompare(input string tag, input bit sop, input logic [31:0] a,
                                input logic [31:0] b);
    logic [31:0] eq, er;
    logic        edz;
    int          cyc;
    refModel(sop, a, b, eq, er, edz);
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
    checkOutput({tag, "_q"}, quotient, eq);
    checkOutput({tag, "_r"}, remainder, er);
  endtask

  initial begin
    int doneCount;
    logic [31:0] ra, rb;
    bit rs;
    rst_n     = 1'b0;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_quotient", quotient, 32'd0);
    checkOutput("reset_remainder", remainder, 32'd0);
    checkOutput("reset_dbz", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;

    applyStimulus(1'b0, 32'd100, 32'd7, 0);
    applyStimulus(1'b1, -32'sd100, 32'd7, 0);
    applyStimulus(1'b1, 32'd100, -32'sd7, 0);
    applyStimulus(1'b1, -32'sd100, -32'sd7, 0);
    applyStimulus(1'b0, 32'h1234_5678, 32'd0, 0);
    applyStimulus(1'b1, 32'h1234_5678, 32'd0, 0);
    applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    applyStimulus(1'b0, 32'd5, 32'd9, 0);
    applyStimulus(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    applyStimulus(1'b1, 32'h8000_0000, 32'd1, 0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 0) rb = $urandom_range(0, 15);
      if (i % 7 == 0) rb = -$urandom_range(1, 9);
      rs = 1'($urandom_range(0, 1));
      applyStimulus(rs, ra, rb, 0);
    end

    applyStimulus(1'b0, 32'd1000, 32'd33, 5);
    applyStimulus(1'b1, -32'sd12345, 32'd17, 20);

    // start held high across two operations
    @(negedge clk);
    start     = 1'b1;
    signed_op = 1'b0;
    dividend  = 32'd999;
    divisor   = 32'd10;
    @(posedge clk);
    #1;
    signed_op = 1'b1;
    dividend  = -32'sd77;
    divisor   = 32'd5;
    @(negedge clk);
    waitAndCompare("b2b_first", 1'b0, 32'd999, 32'd10);
    @(negedge clk);
    checkOutput("b2b_gap_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    checkOutput("b2b_second_busy", {31'd0, busy}, 32'd1);
    start = 1'b0;
    waitAndCompare("b2b_second", 1'b1, -32'sd77, 32'd5);
    @(negedge clk);

    // asynchronous reset while iterating
    applyStimulus(1'b0, 32'd500, 32'd7, 0);
    @(negedge clk);
    start     = 1'b1;
    signed_op = 1'b0;
    dividend  = 32'hDEAD_BEEF;
    divisor   = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset_done", {31'd0, done}, 32'd0);
    checkOutput("midreset_quotient", quotient, 32'd0);
    checkOutput("midreset_remainder", remainder, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    doneCount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) doneCount++;
    end
    checkOutput("no_done_after_reset", doneCount, 32'd0);
    applyStimulus(1'b1, -32'sd1000, 32'd7, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
